// File: rtl/pulpissimo_rst_conditioner.sv
// pulpissimo_rst_conditioner
//
// Board-level reset conditioner that sits upstream of the PULPissimo SoC top.
// It synchronises the raw reset button and the clock-source lock flag and
// debounces the button. It holds the SoC in reset until the clock is locked.
// After lock, it keeps the reset asserted for a guaranteed minimum time once
// the button is released.
//
// Ports
//   ref_clk       in   single clock, all logic on the rising edge
//   pad_reset     in   synchronous active-high block reset
//   btn_raw_i     in   raw reset button (async, active-high, bouncing)
//   clk_locked_i  in   clock-source lock flag (async, active-high)
//   soc_rst_n_o   out  registered active-low SoC reset (drives pad_reset_n)
//   rst_active_o  out  inverse of soc_rst_n_o, for an LED
//   btn_event_o   out  one-cycle pulse per debounced button press
//   rst_count_o   out  reset releases since pad_reset, saturating at 255
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_LOCK | clock not locked, SoC held in reset
// HOLD      | locked, counting the minimum reset pulse (button extends it)
// RUN       | SoC released

module pulpissimo_rst_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int HOLD_CYCLES     = 1024
) (
   input  logic       ref_clk,
   input  logic       pad_reset,
   input  logic       btn_raw_i,
   input  logic       clk_locked_i,
   output logic       soc_rst_n_o,
   output logic       rst_active_o,
   output logic       btn_event_o,
   output logic [7:0] rst_count_o
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(HOLD_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] btn_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   btn_sync;
   logic                   lock_sync;

   logic [DEB_W-1:0]       deb_cnt;
   logic                   btn_stable;
   logic                   btn_event;

   state_t                 state_q;
   state_t                 state_d;
   logic [HOLD_W-1:0]      hold_cnt_q;
   logic [HOLD_W-1:0]      hold_cnt_d;
   logic [7:0]             rst_count_q;
   logic [7:0]             rst_count_d;
   logic                   soc_rst_n_q;

   // synchronisers
   always_ff @(posedge ref_clk) begin
      if (pad_reset) begin
         btn_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw_i};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], clk_locked_i};
      end
   end

   assign btn_sync  = btn_sync_q[SYNC_STAGES-1];
   assign lock_sync = lock_sync_q[SYNC_STAGES-1];

   // debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
   // differing samples. The press event is registered alongside the level
   // change so the FSM sees it on the very next edge.
   always_ff @(posedge ref_clk) begin
      if (pad_reset) begin
         deb_cnt    <= '0;
         btn_stable <= 1'b0;
         btn_event  <= 1'b0;
      end else begin
         btn_event <= 1'b0;
         if (btn_sync == btn_stable) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            btn_stable <= btn_sync;
            btn_event  <= btn_sync;
            deb_cnt    <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   // reset sequencing FSM
   always_ff @(posedge ref_clk) begin
      if (pad_reset) begin
         state_q     <= WAIT_LOCK;
         hold_cnt_q  <= '0;
         rst_count_q <= '0;
         soc_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         rst_count_q <= rst_count_d;
         soc_rst_n_q <= (state_d == RUN);
      end
   end

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      rst_count_d = rst_count_q;
      case (state_q)
         WAIT_LOCK: begin
            if (lock_sync) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         HOLD: begin
            if (!lock_sync) begin
               state_d = WAIT_LOCK;
            end else if (btn_stable) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = RUN;
               if (rst_count_q != 8'hFF) begin
                  rst_count_d = rst_count_q + 8'd1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         RUN: begin
            // lock loss takes priority over a simultaneous button press
            if (!lock_sync) begin
               state_d = WAIT_LOCK;
            end else if (btn_event) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase
   end

   assign soc_rst_n_o  = soc_rst_n_q;
   assign rst_active_o = ~soc_rst_n_q;
   assign btn_event_o  = btn_event;
   assign rst_count_o  = rst_count_q;

endmodule

// File: tb/tb_pulpissimo_rst_conditioner.sv
// Testbench for pulpissimo_rst_conditioner (SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=8). A cycle-level behavioural model runs in
// lock-step with the DUT and every output is compared each cycle. Directed
// scenarios add explicit latency/count checks, followed by a randomized phase.

module tb_pulpissimo_rst_conditioner;

   localparam int S = 2;
   localparam int D = 4;
   localparam int H = 8;

   localparam int M_WAIT = 0;
   localparam int M_HOLD = 1;
   localparam int M_RUN  = 2;

   logic       ref_clk = 1'b0;
   logic       pad_reset;
   logic       btn_raw_i;
   logic       clk_locked_i;
   logic       soc_rst_n_o;
   logic       rst_active_o;
   logic       btn_event_o;
   logic [7:0] rst_count_o;

   int n_checks = 0;
   int n_errors = 0;
   int ev_count = 0;
   int low_count = 0;

   // behavioural model state
   bit m_bq[$];
   bit m_lq[$];
   bit m_seen[$];
   bit m_stable = 1'b0;
   bit m_event  = 1'b0;
   int m_state  = M_WAIT;
   int m_hold   = 0;
   int m_count  = 0;

   pulpissimo_rst_conditioner #(
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H)
   ) dut (
      .ref_clk     (ref_clk),
      .pad_reset   (pad_reset),
      .btn_raw_i   (btn_raw_i),
      .clk_locked_i(clk_locked_i),
      .soc_rst_n_o (soc_rst_n_o),
      .rst_active_o(rst_active_o),
      .btn_event_o (btn_event_o),
      .rst_count_o (rst_count_o)
   );

   always #5 ref_clk = ~ref_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advances the model by one rising edge using the inputs the DUT sampled.
   function automatic void model_step();
      bit old_bsync, old_lsync, old_stable, old_event, all_diff;
      if (pad_reset) begin
         m_bq.delete();
         m_lq.delete();
         repeat (S) begin
            m_bq.push_back(1'b0);
            m_lq.push_back(1'b0);
         end
         m_seen.delete();
         m_stable = 1'b0;
         m_event  = 1'b0;
         m_state  = M_WAIT;
         m_hold   = 0;
         m_count  = 0;
         return;
      end
      old_bsync  = m_bq[S-1];
      old_lsync  = m_lq[S-1];
      old_stable = m_stable;
      old_event  = m_event;
      m_bq.push_front(btn_raw_i);
      void'(m_bq.pop_back());
      m_lq.push_front(clk_locked_i);
      void'(m_lq.pop_back());

      // new level accepted when the last D synchronised samples all disagree
      m_seen.push_back(old_bsync);
      if (m_seen.size() > D) void'(m_seen.pop_front());
      all_diff = (m_seen.size() == D);
      foreach (m_seen[i]) if (m_seen[i] == old_stable) all_diff = 1'b0;
      m_event = 1'b0;
      if (all_diff) begin
         m_stable = !old_stable;
         m_event  = m_stable;
         m_seen.delete();
      end

      case (m_state)
         M_WAIT: if (old_lsync) begin
            m_state = M_HOLD;
            m_hold  = 0;
         end
         M_HOLD: begin
            if (!old_lsync) m_state = M_WAIT;
            else if (old_stable) m_hold = 0;
            else if (m_hold == H - 1) begin
               m_state = M_RUN;
               if (m_count < 255) m_count++;
            end else m_hold++;
         end
         default: begin
            if (!old_lsync) m_state = M_WAIT;
            else if (old_event) begin
               m_state = M_HOLD;
               m_hold  = 0;
            end
         end
      endcase
   endfunction

   task automatic step();
      @(posedge ref_clk);
      model_step();
      #1;
      check_val("soc_rst_n", 32'(soc_rst_n_o), 32'(m_state == M_RUN));
      check_val("rst_active", 32'(rst_active_o), 32'(m_state != M_RUN));
      check_val("btn_event", 32'(btn_event_o), 32'(m_event));
      check_val("rst_count", 32'(rst_count_o), 32'(m_count));
      if (btn_event_o === 1'b1) ev_count++;
      if (soc_rst_n_o !== 1'b1) low_count++;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) step();
   endtask

   // Steps until soc_rst_n_o equals val; n = limit+1 means the bound expired.
   task automatic wait_soc(input logic val, input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (soc_rst_n_o !== val && n <= limit);
   endtask

   initial begin
      int n;
      int timeouts;
      int btn_left;
      int lock_left;

      // 1. power-up
      pad_reset    = 1'b1;
      btn_raw_i    = 1'b0;
      clk_locked_i = 1'b1;
      run_cycles(3);
      check_val("reset_soc", 32'(soc_rst_n_o), 32'd0);
      check_val("reset_led", 32'(rst_active_o), 32'd1);
      check_val("reset_cnt", 32'(rst_count_o), 32'd0);
      check_val("reset_evt", 32'(btn_event_o), 32'd0);
      pad_reset = 1'b0;
      wait_soc(1'b1, 30, n);
      check_val("powerup_latency", n, 32'd11);
      check_val("powerup_count", 32'(rst_count_o), 32'd1);

      // 2. bounce rejection
      ev_count  = 0;
      low_count = 0;
      for (int i = 0; i < 10; i++) begin
         btn_raw_i = (i % 2 == 0);
         run_cycles(2);
      end
      btn_raw_i = 1'b0;
      run_cycles(10);
      check_val("bounce_events", ev_count, 32'd0);
      check_val("bounce_low", low_count, 32'd0);
      check_val("bounce_count", 32'(rst_count_o), 32'd1);

      // 3. clean press
      ev_count  = 0;
      btn_raw_i = 1'b1;
      wait_soc(1'b0, 20, n);
      check_val("press_latency", n, 32'd7);
      run_cycles(30 - n);
      btn_raw_i = 1'b0;
      wait_soc(1'b1, 40, n);
      check_val("release_latency", n, 32'd14);
      check_val("press_events", ev_count, 32'd1);
      check_val("press_count", 32'(rst_count_o), 32'd2);

      // 4. one-cycle lock glitch
      clk_locked_i = 1'b0;
      step();
      clk_locked_i = 1'b1;
      wait_soc(1'b0, 10, n);
      check_val("glitch_assert", n + 1, 32'd3);
      wait_soc(1'b1, 30, timeouts);
      check_val("glitch_release", n + 1 + timeouts, 32'd12);
      check_val("glitch_count", 32'(rst_count_o), 32'd3);

      // 5. lock loss coincident with press event, then pad_reset mid-HOLD
      btn_raw_i = 1'b1;
      run_cycles(4);
      clk_locked_i = 1'b0;
      step();
      clk_locked_i = 1'b1;
      step();
      check_val("simul_event", 32'(btn_event_o), 32'd1);
      step();
      check_val("simul_soc", 32'(soc_rst_n_o), 32'd0);
      run_cycles(3);
      btn_raw_i = 1'b0;
      run_cycles(10);
      check_val("midhold_soc", 32'(soc_rst_n_o), 32'd0);
      pad_reset = 1'b1;
      step();
      check_val("midhold_rst_soc", 32'(soc_rst_n_o), 32'd0);
      check_val("midhold_rst_cnt", 32'(rst_count_o), 32'd0);
      pad_reset = 1'b0;
      wait_soc(1'b1, 30, n);
      check_val("after_rst_latency", n, 32'd11);

      // 6. saturation
      timeouts = 0;
      for (int i = 0; i < 300; i++) begin
         btn_raw_i = 1'b1;
         run_cycles(8);
         btn_raw_i = 1'b0;
         wait_soc(1'b1, 40, n);
         if (n > 40) timeouts++;
      end
      check_val("sat_timeouts", timeouts, 32'd0);
      check_val("sat_count", 32'(rst_count_o), 32'd255);

      // randomized phase
      btn_left  = 0;
      lock_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (btn_left == 0) begin
            btn_raw_i = 1'($urandom_range(0, 1));
            btn_left  = $urandom_range(1, 12);
         end
         btn_left--;
         if (lock_left == 0) begin
            clk_locked_i = ($urandom_range(0, 9) != 0);
            lock_left    = clk_locked_i ? $urandom_range(10, 80) : $urandom_range(1, 5);
         end
         lock_left--;
         pad_reset = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
